// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide owning HI/LO; 34 cycles start-to-done, one op per 35 cycles.
// No queueing: start is taken only in IDLE, MTHI/MTLO are dropped while busy or done is high.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] rs_data,
   input  logic [WIDTH-1:0] rt_data,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

   state_t             state, state_nxt;
   logic [CW-1:0]      count;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   opb;
   logic               is_div, sign_a, sign_b, div0;

   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_nxt;
   logic [WIDTH:0]     div_sh;
   logic [WIDTH-1:0]   div_diff;
   logic               div_ge;
   logic [2*WIDTH-1:0] div_nxt;
   logic [2*WIDTH-1:0] mul_res;
   logic [WIDTH-1:0]   rem_res, quo_res;

   // op[0]=0 selects the signed variants (MULT/DIV)
   assign a_neg = ~op[0] & rs_data[WIDTH-1];
   assign b_neg = ~op[0] & rt_data[WIDTH-1];
   assign a_mag = a_neg ? -rs_data : rs_data;
   assign b_mag = b_neg ? -rt_data : rt_data;

   assign mul_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, opb};
   assign mul_nxt = prod[0] ? {mul_sum, prod[WIDTH-1:1]} : {1'b0, prod[2*WIDTH-1:1]};

   // Shifted remainder needs one extra bit; when it is >= divisor the difference fits in WIDTH
   assign div_sh   = prod[2*WIDTH-1:WIDTH-1];
   assign div_ge   = div_sh >= {1'b0, opb};
   assign div_diff = div_sh[WIDTH-1:0] - opb;
   assign div_nxt  = div_ge ? {div_diff, prod[WIDTH-2:0], 1'b1}
                            : {div_sh[WIDTH-1:0], prod[WIDTH-2:0], 1'b0};

   assign mul_res = (sign_a ^ sign_b) ? -prod : prod;
   assign rem_res = sign_a ? -prod[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH];
   assign quo_res = div0 ? {WIDTH{1'b1}}
                         : ((sign_a ^ sign_b) ? -prod[WIDTH-1:0] : prod[WIDTH-1:0]);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         S_IDLE: if (start) state_nxt = S_CALC;
         S_CALC: begin
            busy = 1'b1;
            if (count == CW'(1)) state_nxt = S_FIX;
         end
         S_FIX: begin
            busy      = 1'b1;
            state_nxt = S_DONE;
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hi     <= '0;
         lo     <= '0;
         count  <= '0;
         prod   <= '0;
         opb    <= '0;
         is_div <= 1'b0;
         sign_a <= 1'b0;
         sign_b <= 1'b0;
         div0   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (hi_we) hi <= wdata;
               if (lo_we) lo <= wdata;
               if (start) begin
                  is_div <= op[1];
                  sign_a <= a_neg;
                  sign_b <= b_neg;
                  div0   <= op[1] & (rt_data == '0);
                  count  <= CW'(WIDTH);
                  // Multiply shifts the multiplier out of the low half; divide shifts the dividend
                  if (op[1]) begin
                     prod <= {{WIDTH{1'b0}}, a_mag};
                     opb  <= b_mag;
                  end else begin
                     prod <= {{WIDTH{1'b0}}, b_mag};
                     opb  <= a_mag;
                  end
               end
            end
            S_CALC: begin
               prod  <= is_div ? div_nxt : mul_nxt;
               count <= count - CW'(1);
            end
            S_FIX: begin
               if (is_div) {hi, lo} <= {rem_res, quo_res};
               else        {hi, lo} <= mul_res;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

- Sequential multiply/divide unit that owns the MIPS HI/LO register pair.
- It accepts MULT, MULTU, DIV and DIVU requests from the execute stage, iterates over 32 cycles, and writes the 64-bit result into HI/LO.
- It serves MFHI/MFLO reads through its hi/lo outputs and MTHI/MTLO writes through its write ports.
- The `busy` output is the stall source for the pipeline control.

## Interface
Parameters:
- `WIDTH`, default 32: operand width. The iteration count equals `WIDTH`.

Ports:
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `reset_n` input, 1 bit: asynchronous, active-low reset.
- `start` input, 1 bit: request strobe; sampled only in IDLE.
- `op` input, 2 bits: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU; sampled with `start`.
- `rs_data` input, `WIDTH` bits: multiplicand / dividend.
- `rt_data` input, `WIDTH` bits: multiplier / divisor.
- `hi_we` input, 1 bit: MTHI write enable.
- `lo_we` input, 1 bit: MTLO write enable.
- `wdata` input, `WIDTH` bits: data for MTHI/MTLO.
- `busy` output, 1 bit: high while an operation is in flight.
- `done` output, 1 bit: one-cycle pulse; HI/LO hold the new result.
- `hi` output, `WIDTH` bits: HI register (MFHI source).
- `lo` output, `WIDTH` bits: LO register (MFLO source).

## Operation
FSM states:
- IDLE: `start=1` latches `op`, the operand magnitudes and the sign flags, then moves to CALC. The count register loads `WIDTH`.
- CALC, multiply: radix-2 shift-add on the 64-bit {acc, multiplier} register.
- CALC, divide: restoring division on a 64-bit {remainder, quotient} register.
- CALC exit: after exactly `WIDTH` iterations, go to FIX.
- FIX: apply sign correction, write HI/LO, go to DONE.
- DONE: `done=1` for this single cycle, then return to IDLE. `start` is ignored in DONE.

Arithmetic rules:
- MULT/MULTU: {HI,LO} = rs × rt, full 64-bit product. MULT is two's-complement; MULTU is unsigned.
- Signed multiply: multiply the magnitudes, then negate the 64-bit product when sign(rs) XOR sign(rt).
- DIV/DIVU: LO = quotient, HI = remainder.
- Signed quotient truncates toward zero. The remainder takes the sign of the dividend.
- 0x80000000 / 0xFFFFFFFF (DIV) gives LO=0x80000000, HI=0. No trap.
- Divide by zero (DIV or DIVU): LO=0xFFFFFFFF, HI=rs_data. The unit still takes the full latency.
- Operands are captured at start. Changes on `rs_data`/`rt_data` during CALC have no effect.

MTHI/MTLO writes:
- Honoured only in IDLE. In IDLE, `hi_we`/`lo_we` write `wdata` on the clock edge.
- Dropped while `busy=1` or in DONE. Pipeline control stalls them via `busy`.
- `start` with `hi_we`/`lo_we` in the same IDLE cycle: both are accepted. The write lands immediately, and the operation result overwrites HI/LO at FIX.
- `hi_we` and `lo_we` together: both registers are written with `wdata`.

Reads and requests:
- `hi`/`lo` are direct register outputs. During CALC/FIX they still show the previous values; control must stall MFHI/MFLO while `busy=1`.
- `start` during CALC/FIX/DONE is ignored. No queueing.

Reset:
- `reset_n` low at any time, including mid-operation, forces IDLE asynchronously.
- Reset values: `hi`=0, `lo`=0, `busy`=0, `done`=0, count=0, datapath registers=0.
- An interrupted operation is discarded; HI/LO are not written.

## Timing
- Start accepted at edge E0, with IDLE and `start` high in cycle 0.
- Cycles 1..32: CALC, `busy=1`.
- Cycle 33: FIX, `busy=1`. HI/LO are written at the end of cycle 33.
- Cycle 34: DONE, `done=1`, `busy=0`; new HI/LO are visible.
- Cycle 35: IDLE. The earliest next accepted `start` is in cycle 35.
- Latency: 34 cycles from start to done. Throughput: one operation per 35 cycles.
- `busy` is registered and rises in the cycle after `start` is accepted. Control must stall MFHI/MFLO/MTHI/MTLO in the start cycle itself by decode.
- `done` and `busy` are never high together.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `done` in cycle 34; HI=0xFFFFFFFE, LO=0x00000001; `busy` high in cycles 1–33 only.
- MULT 0xFFFFFFFE (−2) × 0x00000003 → HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULT 0x80000000 × 0x80000000 → HI=0x40000000, LO=0.
- DIV −7 (0xFFFFFFF9) / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 → LO=14, HI=2. DIV 0x80000000/−1 → LO=0x80000000, HI=0.
- DIVU 0x1234 / 0 → LO=0xFFFFFFFF, HI=0x1234 after 34 cycles. DIV by 0 gives the same mapping.
- MTHI 0xAAAA5555 in IDLE → `hi` updates the next cycle. MTLO pulsed in cycle 10 of an operation → ignored. Second `start` in cycle 5 → ignored; only the first result is written.
- `reset_n` pulled low in cycle 20 of a MULT, with HI preloaded to 0x1 → `hi`=`lo`=0, `busy`=0 immediately. No `done` is ever produced. A new `start` after release completes normally.
